// File: rtl/matmul_mac_ctrl_if.sv
// Purpose: command, operand-read and result-write signals of the matmul sequencer.
// Latency: wiring only, no storage.
// Backpressure: none; the storage answers reads combinationally and always accepts writes.
interface matmul_mac_ctrl_if #(
  parameter int IW   = 3,
  parameter int DW   = 4,
  parameter int ACCW = 10
);
  logic            start;
  logic            abort;
  logic [IW-1:0]   a_row;
  logic [IW-1:0]   a_col;
  logic [IW-1:0]   b_row;
  logic [IW-1:0]   b_col;
  logic [DW-1:0]   a_data;
  logic [DW-1:0]   b_data;
  logic            c_wr_en;
  logic [IW-1:0]   c_row;
  logic [IW-1:0]   c_col;
  logic [ACCW-1:0] c_data;
  logic            busy;
  logic            done;

  // Command logic plus operand/result storage.
  modport master (
    output start, abort, a_data, b_data,
    input  a_row, a_col, b_row, b_col, c_wr_en, c_row, c_col, c_data, busy, done
  );

  // The sequencer itself.
  modport slave (
    input  start, abort, a_data, b_data,
    output a_row, a_col, b_row, b_col, c_wr_en, c_row, c_col, c_data, busy, done
  );
endinterface

// File: rtl/matmul_mac_ctrl.sv
// Purpose: walks (i,j,k) for C = A x B, one MAC per cycle, one C write per element.
// Latency: N ACC cycles + 1 WRITE cycle per element; done at cycle N*N*(N+1)+1 after start.
// Backpressure: none; abort returns to IDLE at once, start outside IDLE is ignored.
module matmul_mac_ctrl #(
  parameter int N    = 2,
  parameter int IW   = 3,
  parameter int DW   = 4,
  parameter int ACCW = 10
) (
  input logic               clk,
  input logic               rst_n,
  matmul_mac_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [IW-1:0]   j_q, j_d;
  logic [IW-1:0]   k_q, k_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [ACCW-1:0] c_last_q, c_last_d;

  logic [2*DW-1:0] prod;
  logic [ACCW-1:0] prod_ext;
  logic [ACCW-1:0] acc_sum;

  // Bitwise ripple-carry sum; the carry out of the top bit is dropped, so the
  // result wraps modulo 2^ACCW.
  function automatic logic [ACCW-1:0] ripple_add(input logic [ACCW-1:0] a,
                                                 input logic [ACCW-1:0] b);
    logic [ACCW-1:0] s;
    logic            c;
    s = '0;
    c = 1'b0;
    for (int n = 0; n < ACCW; n++) begin
      s[n] = a[n] ^ b[n] ^ c;
      c    = (a[n] & b[n]) | (c & (a[n] ^ b[n]));
    end
    return s;
  endfunction

  // Full-width unsigned product, then sized onto the accumulator path.
  always_comb begin
    prod     = (2*DW)'(bus.a_data) * (2*DW)'(bus.b_data);
    prod_ext = ACCW'(prod);
    acc_sum  = ripple_add(acc_q, prod_ext);
  end

  // Next-state and counter update; abort outside IDLE overrides everything.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    c_last_d = c_last_q;

    case (state_q)
      S_IDLE: begin
        i_d   = '0;
        j_d   = '0;
        k_d   = '0;
        acc_d = '0;
        if (bus.start) state_d = S_ACC;
      end
      S_ACC: begin
        acc_d = acc_sum;
        if (k_q == LAST) state_d = S_WRITE;
        else             k_d     = k_q + IW'(1);
      end
      S_WRITE: begin
        c_last_d = acc_q;
        acc_d    = '0;
        k_d      = '0;
        if (j_q == LAST) begin
          j_d = '0;
          i_d = i_q + IW'(1);
        end else begin
          j_d = j_q + IW'(1);
        end
        if ((i_q == LAST) && (j_q == LAST)) begin
          state_d = S_DONE;
          i_d     = '0;
          j_d     = '0;
        end else begin
          state_d = S_ACC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        acc_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // An aborted WRITE produces no write, so the held result is left alone.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      i_d      = '0;
      j_d      = '0;
      k_d      = '0;
      acc_d    = '0;
      c_last_d = c_last_q;
    end
  end

  // State, counters, accumulator and last written result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      c_last_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      c_last_q <= c_last_d;
    end
  end

  // Output decodes straight from registered state; abort masks the strobes.
  always_comb begin
    bus.a_row   = i_q;
    bus.a_col   = k_q;
    bus.b_row   = k_q;
    bus.b_col   = j_q;
    bus.c_row   = i_q;
    bus.c_col   = j_q;
    bus.c_wr_en = (state_q == S_WRITE) && !bus.abort;
    bus.done    = (state_q == S_DONE) && !bus.abort;
    bus.busy    = (state_q != S_IDLE);
    bus.c_data  = bus.c_wr_en ? acc_q : c_last_q;
  end

endmodule
